// File: rtl/apb_router_pkg.sv
// rtl/apb_router_pkg.sv - shared types, error codes and default address map for the APB router
package apb_router_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      M_SETUP  = 2'b01,
      M_ACCESS = 2'b10,
      DECERR   = 2'b11
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_DECODE  = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // Default SoC peripheral map, used by integrators to program start/end inputs.
   localparam logic [31:0] FLL_START_ADDR      = 32'h1A10_0000;
   localparam logic [31:0] FLL_END_ADDR        = 32'h1A10_0FFF;
   localparam logic [31:0] GPIO_START_ADDR     = 32'h1A10_1000;
   localparam logic [31:0] GPIO_END_ADDR       = 32'h1A10_1FFF;
   localparam logic [31:0] UDMA_START_ADDR     = 32'h1A10_2000;
   localparam logic [31:0] UDMA_END_ADDR       = 32'h1A10_3FFF;
   localparam logic [31:0] SOC_CTRL_START_ADDR = 32'h1A10_4000;
   localparam logic [31:0] SOC_CTRL_END_ADDR   = 32'h1A10_4FFF;
   localparam logic [31:0] ADV_TIMER_START_ADDR = 32'h1A10_5000;
   localparam logic [31:0] ADV_TIMER_END_ADDR  = 32'h1A10_5FFF;
   localparam logic [31:0] EVENT_START_ADDR    = 32'h1A10_6000;
   localparam logic [31:0] EVENT_END_ADDR      = 32'h1A10_6FFF;
   localparam logic [31:0] TIMER_START_ADDR    = 32'h1A10_B000;
   localparam logic [31:0] TIMER_END_ADDR      = 32'h1A10_BFFF;
   localparam logic [31:0] DEBUG_START_ADDR    = 32'h1A11_0000;
   localparam logic [31:0] DEBUG_END_ADDR      = 32'h1A11_FFFF;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational first-match address range decoder
module apb_addr_decoder
   import apb_router_pkg::*;
#(
   parameter int NB_MASTER      = 11,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int IDX_W          = idx_width(NB_MASTER)
)(
   input  logic [APB_ADDR_WIDTH-1:0]           addr_i,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i,
   input  logic [NB_MASTER-1:0]                en_mask_i,
   output logic                                match_o,
   output logic [IDX_W-1:0]                    idx_o
);

   // Scan from the top so the lowest matching index is written last and wins.
   always_comb begin
      match_o = 1'b0;
      idx_o   = '0;
      for (int i = NB_MASTER - 1; i >= 0; i--) begin
         if (en_mask_i[i] &&
             (addr_i >= start_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
             (addr_i <= end_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
            match_o = 1'b1;
            idx_o   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/apb_periph_router.sv
// rtl/apb_periph_router.sv - APB 1-to-N router with decode error, timeout, abort and error log
module apb_periph_router
   import apb_router_pkg::*;
#(
   parameter int NB_MASTER      = 11,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int ERR_CNT_WIDTH  = 8
)(
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr_i,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr_i,
   input  logic [NB_MASTER-1:0]                en_mask_i,
   input  logic [APB_ADDR_WIDTH-1:0]           s_paddr_i,
   input  logic [APB_DATA_WIDTH-1:0]           s_pwdata_i,
   input  logic                                s_pwrite_i,
   input  logic                                s_psel_i,
   input  logic                                s_penable_i,
   output logic [APB_DATA_WIDTH-1:0]           s_prdata_o,
   output logic                                s_pready_o,
   output logic                                s_pslverr_o,
   output logic [APB_ADDR_WIDTH-1:0]           m_paddr_o,
   output logic [APB_DATA_WIDTH-1:0]           m_pwdata_o,
   output logic                                m_pwrite_o,
   output logic [NB_MASTER-1:0]                m_psel_o,
   output logic [NB_MASTER-1:0]                m_penable_o,
   input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] m_prdata_i,
   input  logic [NB_MASTER-1:0]                m_pready_i,
   input  logic [NB_MASTER-1:0]                m_pslverr_i,
   input  logic                                clr_err_i,
   output logic [ERR_CNT_WIDTH-1:0]            err_cnt_o,
   output logic [APB_ADDR_WIDTH-1:0]           err_addr_o,
   output logic [1:0]                          err_type_o
);

   localparam int IDX_W = idx_width(NB_MASTER);
   localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          sel_q, sel_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;
   logic [TW-1:0]             tmo_q, tmo_d;
   logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
   logic [APB_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
   logic [1:0]                err_type_q, err_type_d;

   logic                      dec_match;
   logic [IDX_W-1:0]          dec_idx;
   logic [NB_MASTER-1:0]      sel_oh;
   logic [APB_DATA_WIDTH-1:0] prdata_sel;
   logic                      pready_sel, pslverr_sel;
   logic                      tmo_hit;
   logic                      log_evt;
   logic [1:0]                log_type;

   apb_addr_decoder #(
      .NB_MASTER      (NB_MASTER),
      .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
      .IDX_W          (IDX_W)
   ) u_decoder (
      .addr_i       (s_paddr_i),
      .start_addr_i (start_addr_i),
      .end_addr_i   (end_addr_i),
      .en_mask_i    (en_mask_i),
      .match_o      (dec_match),
      .idx_o        (dec_idx)
   );

   always_comb begin
      sel_oh      = '0;
      prdata_sel  = '0;
      pready_sel  = 1'b0;
      pslverr_sel = 1'b0;
      for (int i = 0; i < NB_MASTER; i++) begin
         if (sel_q == IDX_W'(i)) begin
            sel_oh[i]   = 1'b1;
            prdata_sel  = m_prdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            pready_sel  = m_pready_i[i];
            pslverr_sel = m_pslverr_i[i];
         end
      end
   end

   assign tmo_hit = (TIMEOUT_CYCLES > 0) && (tmo_q == TMO_LAST);

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      tmo_d       = '0;
      s_prdata_o  = '0;
      s_pready_o  = 1'b0;
      s_pslverr_o = 1'b0;
      m_psel_o    = '0;
      m_penable_o = '0;
      log_evt     = 1'b0;
      log_type    = ERR_NONE;
      case (state_q)
         IDLE: begin
            if (s_psel_i && !s_penable_i) begin
               paddr_d = s_paddr_i;
               if (dec_match) begin
                  sel_d    = dec_idx;
                  pwdata_d = s_pwdata_i;
                  pwrite_d = s_pwrite_i;
                  state_d  = M_SETUP;
               end else begin
                  state_d  = DECERR;
               end
            end
         end
         M_SETUP: begin
            m_psel_o = sel_oh;
            state_d  = s_psel_i ? M_ACCESS : IDLE;
         end
         M_ACCESS: begin
            m_psel_o    = sel_oh;
            m_penable_o = sel_oh;
            s_prdata_o  = prdata_sel;
            s_pready_o  = pready_sel;
            s_pslverr_o = pslverr_sel;
            // Abort takes priority: a withdrawn transfer is never answered or logged.
            if (!s_psel_i) begin
               state_d = IDLE;
            end else if (pready_sel) begin
               state_d = IDLE;
            end else if (tmo_hit) begin
               s_prdata_o  = '0;
               s_pready_o  = 1'b1;
               s_pslverr_o = 1'b1;
               log_evt     = 1'b1;
               log_type    = ERR_TIMEOUT;
               state_d     = IDLE;
            end else begin
               tmo_d = (TIMEOUT_CYCLES > 0) ? tmo_q + 1'b1 : '0;
            end
         end
         DECERR: begin
            s_pready_o  = 1'b1;
            s_pslverr_o = 1'b1;
            log_evt     = 1'b1;
            log_type    = ERR_DECODE;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A new error outranks a simultaneous clear so the event is never lost.
   always_comb begin
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
      err_type_d = err_type_q;
      if (log_evt) begin
         if (clr_err_i)
            err_cnt_d = ERR_CNT_WIDTH'(1);
         else if (!(&err_cnt_q))
            err_cnt_d = err_cnt_q + 1'b1;
         err_addr_d = paddr_q;
         err_type_d = log_type;
      end else if (clr_err_i) begin
         err_cnt_d  = '0;
         err_addr_d = '0;
         err_type_d = ERR_NONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         pwrite_q   <= 1'b0;
         tmo_q      <= '0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         err_type_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         pwrite_q   <= pwrite_d;
         tmo_q      <= tmo_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
         err_type_q <= err_type_d;
      end
   end

   assign m_paddr_o  = paddr_q;
   assign m_pwdata_o = pwdata_q;
   assign m_pwrite_o = pwrite_q;
   assign err_cnt_o  = err_cnt_q;
   assign err_addr_o = err_addr_q;
   assign err_type_o = err_type_q;

endmodule

// File: tb/tb_apb_periph_router.sv
// tb/tb_apb_periph_router.sv - scoreboard bench for apb_periph_router
module tb_apb_periph_router;

   localparam int NB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_ni;
   logic [NB*32-1:0]  start_addr, end_addr;
   logic [NB-1:0]     en_mask;
   logic [31:0]       s_paddr, s_pwdata;
   logic              s_pwrite, s_psel, s_penable;
   logic [31:0]       s_prdata;
   logic              s_pready, s_pslverr;
   logic [31:0]       m_paddr, m_pwdata;
   logic              m_pwrite;
   logic [NB-1:0]     m_psel, m_penable;
   logic [NB*32-1:0]  m_prdata;
   logic [NB-1:0]     m_pready, m_pslverr;
   logic              clr_err;
   logic [7:0]        err_cnt;
   logic [31:0]       err_addr;
   logic [1:0]        err_type;

   apb_periph_router #(
      .NB_MASTER(NB), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32),
      .TIMEOUT_CYCLES(4), .ERR_CNT_WIDTH(8)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .start_addr_i(start_addr), .end_addr_i(end_addr), .en_mask_i(en_mask),
      .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata), .s_pwrite_i(s_pwrite),
      .s_psel_i(s_psel), .s_penable_i(s_penable),
      .s_prdata_o(s_prdata), .s_pready_o(s_pready), .s_pslverr_o(s_pslverr),
      .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata), .m_pwrite_o(m_pwrite),
      .m_psel_o(m_psel), .m_penable_o(m_penable),
      .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
      .clr_err_i(clr_err), .err_cnt_o(err_cnt), .err_addr_o(err_addr), .err_type_o(err_type)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          waits;
      bit          chk_rd;
      string       name;
   } exp_t;

   exp_t sb[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Peripheral models: port p answers after pwait[p] access cycles.
   int          acc_cnt[NB] = '{default: 0};
   int          pwait[NB];
   logic [31:0] prd[NB];
   logic        pse[NB];

   always_comb begin
      m_pready  = '0;
      m_pslverr = '0;
      m_prdata  = '0;
      for (int p = 0; p < NB; p++) begin
         m_pready[p]          = m_psel[p] & m_penable[p] & (acc_cnt[p] >= pwait[p]);
         m_pslverr[p]         = pse[p];
         m_prdata[p*32 +: 32] = prd[p];
      end
   end

   always @(posedge clk) begin
      for (int p = 0; p < NB; p++)
         acc_cnt[p] <= (m_psel[p] && m_penable[p] && !m_pready[p]) ? acc_cnt[p] + 1 : 0;
   end

   // Monitor: counts slave wait states and checks each completed response.
   int            waits = 0;
   logic [NB-1:0] psel_seen = '0;

   always @(negedge clk) begin
      psel_seen = psel_seen | m_psel;
      if (rst_ni && s_psel && s_penable) begin
         if (s_pready) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_response: got pready with empty scoreboard at %0t", $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (e.chk_rd) check({e.name, " prdata"}, s_prdata, e.rdata);
               check({e.name, " pslverr"}, {31'd0, s_pslverr}, {31'd0, e.err});
               check({e.name, " waits"}, waits, e.waits);
            end
            waits = 0;
         end else begin
            waits++;
         end
      end else begin
         waits = 0;
      end
   end

   task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_waits,
                       input bit chk_rd, input logic [NB-1:0] exp_sel, input string name);
      exp_t e;
      int   budget;
      e.rdata = exp_rd; e.err = exp_err; e.waits = exp_waits; e.chk_rd = chk_rd; e.name = name;
      sb.push_back(e);
      @(posedge clk); #1;
      psel_seen = '0;
      s_paddr = addr; s_pwdata = wdata; s_pwrite = wr; s_psel = 1'b1; s_penable = 1'b0;
      @(posedge clk); #1;
      s_penable = 1'b1;
      budget = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (!s_pready && budget < 40);
      if (!s_pready) begin
         n_vec++;
         n_err++;
         $display("FAIL %s no_response: no s_pready_o within 40 cycles", name);
         sb.delete();
      end
      @(posedge clk); #1;
      s_psel = 1'b0; s_penable = 1'b0;
      check({name, " psel_seen"}, {28'd0, psel_seen}, {28'd0, exp_sel});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0; clr_err = 1'b0;
      s_paddr = '0; s_pwdata = '0; s_pwrite = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
      pwait = '{0, 0, 0, 0};
      prd   = '{32'h1111_0000, 32'hDEAD_BEEF, 32'hC0FF_EE02, 32'h3333_0003};
      pse   = '{1'b0, 1'b0, 1'b0, 1'b0};
      start_addr = {32'h1A11_0000, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000};
      end_addr   = {32'h1A11_FFFF, 32'h1A10_4FFF, 32'h1A10_AFFF, 32'h1A10_0FFF};
      en_mask = 4'b0111;

      repeat (3) @(posedge clk);
      #1;
      check("rst s_resp", {s_prdata[0], s_pready, s_pslverr}, 0);
      check("rst strobes", {m_psel, m_penable}, 0);
      check("rst m_paddr", m_paddr, 0);
      check("rst err_log", {err_cnt, err_type}, 0);
      rst_ni = 1'b1;

      // Overlap of regions 1 and 2 resolves to port 1.
      xfer(32'h1A10_2010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1, 1, 4'b0010, "rd_port1");

      xfer(32'h2000_0000, 32'h1234_5678, 1'b1, 32'h0, 1'b1, 0, 1, 4'b0000, "wr_unmapped");
      check("decerr cnt", err_cnt, 1);
      check("decerr type", err_type, 2'b01);
      check("decerr addr", err_addr, 32'h2000_0000);

      en_mask = 4'b0101;
      xfer(32'h1A10_2010, 32'h0, 1'b0, 32'hC0FF_EE02, 1'b0, 1, 1, 4'b0100, "rd_port2");
      en_mask = 4'b0001;
      xfer(32'h1A10_2010, 32'h0, 1'b0, 32'h0, 1'b1, 0, 1, 4'b0000, "rd_masked");
      check("masked cnt", err_cnt, 2);
      check("masked addr", err_addr, 32'h1A10_2010);

      // Peripheral slverr is forwarded but not logged.
      en_mask = 4'b1111; pse[3] = 1'b1; pwait[3] = 2;
      xfer(32'h1A11_0004, 32'hA5A5_0003, 1'b1, 32'h0, 1'b1, 3, 0, 4'b1000, "wr_port3_slverr");
      check("slverr cnt", err_cnt, 2);
      check("held m_paddr", m_paddr, 32'h1A11_0004);
      check("held m_pwdata", m_pwdata, 32'hA5A5_0003);
      check("held m_pwrite", {31'd0, m_pwrite}, 1);

      pwait[0] = 100;
      xfer(32'h1A10_0010, 32'h0, 1'b0, 32'h0, 1'b1, 4, 1, 4'b0001, "timeout");
      check("timeout cnt", err_cnt, 3);
      check("timeout type", err_type, 2'b10);
      check("timeout addr", err_addr, 32'h1A10_0010);

      pwait[0] = 3;
      xfer(32'h1A10_0020, 32'h0, 1'b0, 32'h1111_0000, 1'b0, 4, 1, 4'b0001, "ready_at_limit");
      check("limit cnt", err_cnt, 3);

      // Abort during M_SETUP.
      @(posedge clk); #1;
      s_paddr = 32'h1A10_1000; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
      @(posedge clk); #1;
      check("abort setup psel", {28'd0, m_psel}, 32'h2);
      s_psel = 1'b0;
      @(posedge clk); #1;
      check("abort strobes", {m_psel, m_penable}, 0);
      check("abort cnt", err_cnt, 3);

      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      check("clear log", {err_cnt, err_type}, 0);
      check("clear addr", err_addr, 0);

      for (int i = 0; i < 300; i++)
         xfer(32'h3000_0000 + 32'(i) * 4, 32'h0, 1'b1, 32'h0, 1'b1, 0, 1, 4'b0000, "decerr_loop");
      check("saturate cnt", err_cnt, 255);
      check("saturate addr", err_addr, 32'h3000_04AC);

      clr_err = 1'b1;
      xfer(32'h2000_0100, 32'h0, 1'b0, 32'h0, 1'b1, 0, 1, 4'b0000, "clr_with_err");
      clr_err = 1'b0;
      check("clr+err cnt", err_cnt, 1);
      check("clr+err type", err_type, 2'b01);
      check("clr+err addr", err_addr, 32'h2000_0100);

      // Asynchronous reset in M_ACCESS.
      pwait[0] = 100;
      @(posedge clk); #1;
      s_paddr = 32'h1A10_0000; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
      @(posedge clk); #1;
      s_penable = 1'b1;
      @(posedge clk); #1;
      check("access penable", {28'd0, m_penable}, 32'h1);
      #2 rst_ni = 1'b0;
      #1;
      check("arst strobes", {m_psel, m_penable}, 0);
      check("arst s_resp", {s_prdata, s_pready, s_pslverr}, 0);
      check("arst m_paddr", m_paddr, 0);
      check("arst err_log", {err_cnt, err_type}, 0);
      s_psel = 1'b0; s_penable = 1'b0;
      @(posedge clk); #1;
      rst_ni = 1'b1;

      pwait[0] = 0;
      xfer(32'h1A10_0000, 32'h0, 1'b0, 32'h1111_0000, 1'b0, 1, 1, 4'b0001, "after_reset");

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_periph_router.md
Name: apb_periph_router

Overview:
Parametrised APB 1-to-N peripheral router. It is the next generation of the SoC peripheral bus wrapper and takes one APB slave port from the SoC interconnect. Each transfer is decoded against runtime-programmable address ranges and a per-region enable mask, then forwarded over a registered request path to one of NB_MASTER peripheral ports. Added over the previous generation: decode-error response, per-transfer pready timeout, abort handling and an error log.

Parameters:
NB_MASTER, 11, number of peripheral ports (1..32)
APB_ADDR_WIDTH, 32, address width
APB_DATA_WIDTH, 32, data width
TIMEOUT_CYCLES, 256, maximum M_ACCESS cycles before forced error; 0 disables the timeout
ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_addr_i  in  NB_MASTER*APB_ADDR_WIDTH  region start (inclusive), slice i belongs to port i
end_addr_i  in  NB_MASTER*APB_ADDR_WIDTH  region end (inclusive)
en_mask_i  in  NB_MASTER  region enable; a disabled region does not match
s_paddr_i  in  APB_ADDR_WIDTH  slave-side address
s_pwdata_i  in  APB_DATA_WIDTH  slave-side write data
s_pwrite_i  in  1  slave-side write flag
s_psel_i  in  1  slave-side select
s_penable_i  in  1  slave-side enable
s_prdata_o  out  APB_DATA_WIDTH  read data returned to the interconnect
s_pready_o  out  1  ready returned to the interconnect
s_pslverr_o  out  1  error returned to the interconnect
m_paddr_o  out  APB_ADDR_WIDTH  registered address, shared by all ports
m_pwdata_o  out  APB_DATA_WIDTH  registered write data, shared by all ports
m_pwrite_o  out  1  registered write flag, shared by all ports
m_psel_o  out  NB_MASTER  one-hot per-port select
m_penable_o  out  NB_MASTER  per-port enable
m_prdata_i  in  NB_MASTER*APB_DATA_WIDTH  per-port read data
m_pready_i  in  NB_MASTER  per-port ready
m_pslverr_i  in  NB_MASTER  per-port error
clr_err_i  in  1  synchronous clear of the error log
err_cnt_o  out  ERR_CNT_WIDTH  saturating error count
err_addr_o  out  APB_ADDR_WIDTH  address of the most recent error
err_type_o  out  2  type of the most recent error: 00 none, 01 decode error, 10 timeout

Behaviour:
- Reset values: every output is 0; FSM is in IDLE; timeout counter is 0.
- Decode:
  - Port i matches when en_mask_i[i] is set and start_i <= s_paddr_i <= end_i (unsigned compare).
  - Overlapping regions resolve to the lowest index.
  - Decode is evaluated only in IDLE, when s_psel_i=1 and s_penable_i=0.
- FSM states and transitions:
  - IDLE: on a slave setup cycle with a match, latch the port index, paddr, pwdata and pwrite, then go to M_SETUP. On a setup cycle with no match, latch paddr and go to DECERR.
  - M_SETUP: drive m_psel_o[sel]=1 and m_penable_o=0; s_pready_o=0; go to M_ACCESS.
  - M_ACCESS: drive m_psel_o[sel]=1 and m_penable_o[sel]=1. Forward s_prdata_o, s_pready_o and s_pslverr_o combinationally from port sel. When m_pready_i[sel]=1, go to IDLE. The timeout counter increments each cycle without ready.
  - DECERR: s_pready_o=1, s_pslverr_o=1, s_prdata_o=0 for exactly one cycle, then go to IDLE.
- Latency:
  - A mapped transfer with a zero-wait peripheral completes in the slave's 2nd access cycle, i.e. one added wait state.
  - A decode error completes in the first access cycle with zero wait states.
- Timeout:
  - Applies only when TIMEOUT_CYCLES>0.
  - In the M_ACCESS cycle where the counter equals TIMEOUT_CYCLES-1 and m_pready_i[sel]=0: drive s_pready_o=1, s_pslverr_o=1, s_prdata_o=0, then go to IDLE. Port strobes drop in the next cycle.
  - If pready arrives in that same cycle, the normal response wins and no timeout is logged.
- Abort: if s_psel_i falls while in M_SETUP or M_ACCESS, go to IDLE the next cycle, deassert all port strobes, and log nothing.
- Outside M_SETUP and M_ACCESS, m_psel_o and m_penable_o are all 0. m_paddr_o, m_pwdata_o and m_pwrite_o hold their last latched values.
- Error log:
  - Logged events are a decode error and a timeout. A peripheral's own pslverr is not logged.
  - On a logged event, err_cnt_o increments and saturates at all-ones; err_addr_o and err_type_o are updated.
  - clr_err_i zeroes the counter, address and type.
  - If clr_err_i coincides with a new error, the new error wins: err_cnt_o=1 and the error fields are captured.
- Asynchronous reset mid-transfer returns the block to IDLE with all strobes low immediately. No response is issued.

Decomposition:
- apb_router_pkg holds:
  - state enum (IDLE, M_SETUP, M_ACCESS, DECERR);
  - err_type constants ERR_NONE, ERR_DECODE, ERR_TIMEOUT;
  - default SoC address map constants (FLL 0x1A100000-0x1A100FFF … DEBUG 0x1A110000-0x1A11FFFF).
- Sub-module apb_addr_decoder: combinational first-match priority decoder. Outputs a match flag and an index of width $clog2(NB_MASTER), minimum 1 bit.

Test Plan:
- Map: region 0 = 0x1A100000-0x1A100FFF, region 1 = 0x1A101000-0x1A10AFFF, region 2 = 0x1A102000-0x1A104FFF, all enabled. Read 0x1A102010 -> only m_psel_o[1] asserted; m_prdata_i slice 1 = 0xDEADBEEF is returned; pready arrives 2 cycles after the setup cycle.
- Write 0x20000000 (unmapped) -> s_pready_o=1, s_pslverr_o=1 in the first access cycle; no port strobed; err_cnt_o=1, err_type_o=01, err_addr_o=0x20000000.
- Clear en_mask_i[1], then access 0x1A102010 -> routed to port 2. Then clear en_mask_i[2] -> decode error.
- TIMEOUT_CYCLES=4, port 0 holds pready=0 -> s_pslverr_o=1 after 4 M_ACCESS cycles; err_type_o=10. A second run with pready rising on the 4th cycle -> normal response, no log entry.
- Drop s_psel_i in M_SETUP -> all m_psel_o=0 the next cycle; err_cnt_o unchanged. Assert rst_ni=0 mid-M_ACCESS -> all outputs 0 immediately.
- 300 decode errors with ERR_CNT_WIDTH=8 -> err_cnt_o=255. clr_err_i coinciding with a decode error -> err_cnt_o=1.
